vga_sync_out: RTL and testbench
===============================

# vga_sync_out

Display-side end of the pixel pipeline: generates 640x480@60 Hz raster timing, publishes the current pixel coordinate to the drawing objects, and samples the 24-bit color returned by the object multiplexer. The returned color is registered toward the VGA DAC together with hsync, vsync and blank. The sync and blank signals are delayed so they align with the drawing/mux pipeline latency. Runs on the 25 MHz pixel clock.

## Interface
- PIPE_DELAY, 1, cycles from pixelX/pixelY presentation until the matching color is valid on redIn/greenIn/blueIn; legal range 1..4
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- clk  in  1  pixel clock; all logic on posedge
- resetN  in  1  asynchronous, active-low reset
- redIn  in  8  red color from the object mux
- greenIn  in  8  green color from the object mux
- blueIn  in  8  blue color from the object mux
- pixelX  out  11  current horizontal count (raw counter, 0..H_TOTAL-1)
- pixelY  out  11  current vertical count (raw counter, 0..V_TOTAL-1)
- startOfFrame  out  1  high while pixelX==0 && pixelY==0
- vgaR  out  8  registered red to DAC
- vgaG  out  8  registered green to DAC
- vgaB  out  8  registered blue to DAC
- hsyncN  out  1  horizontal sync, active low
- vsyncN  out  1  vertical sync, active low
- blankN  out  1  low outside the visible area

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- hCount increments every clk. At H_TOTAL-1 it wraps to 0, and vCount increments. vCount wraps to 0 at V_TOTAL-1 coincident with the hCount wrap.
- pixelX = hCount; pixelY = vCount. Both come straight from the counter registers, with no combinational path from inputs.
- Raw decodes, all per current counter state:
  - active = hCount < H_ACTIVE && vCount < V_ACTIVE
  - hs = hCount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751)
  - vs = vCount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491)
- active, hs and vs pass through a PIPE_DELAY-stage shift register, then the output register stage.
- Output register, every clk:
  - hsyncN = ~hs_d
  - vsyncN = ~vs_d
  - blankN = active_d
  - vgaR/G/B = active_d ? redIn/greenIn/blueIn : 0
- Color is forced to 0 whenever the delayed active is low, regardless of input value.
- No handshake: inputs are sampled unconditionally every cycle; the upstream pipeline must match PIPE_DELAY exactly.

## Timing
- Reset, asynchronous, all outputs and state:
  - hCount, vCount = 0, so pixelX = pixelY = 0 and startOfFrame = 1.
  - Delay-line stages = inactive (active=0, hs=0, vs=0).
  - vgaR/G/B = 0, hsyncN = 1, vsyncN = 1, blankN = 0.
- First rising edge after resetN release: hCount becomes 1.
- Latency: counter state at cycle t → sync/blank/color on the outputs after edge t+PIPE_DELAY+1.
  - Color sampled is the redIn/greenIn/blueIn present in cycle t+PIPE_DELAY.
- startOfFrame is high for exactly one cycle per frame, every 800*525 = 420000 cycles.
- Line wrap (hCount 799→0) and frame wrap (vCount 524→0 on the same edge) occur in one cycle with no idle cycle.
- Reset mid-frame: outputs return to reset values immediately. In-flight delay-line contents are discarded; no stale color or sync appears after release.

## Test plan
- Reset: hold resetN=0 with inputs 8'hFF → pixelX=0, pixelY=0, startOfFrame=1, vgaR/G/B=0, hsyncN=1, vsyncN=1, blankN=0. Release → pixelX=1 after first edge.
- Horizontal timing, PIPE_DELAY=1 → hsyncN low for exactly 96 cycles per line, falling 2 cycles after pixelX=656 is presented. blankN high for 640 cycles per visible line. Line period 800 cycles.
- Vertical timing → vsyncN low for exactly 2 lines (1600 cycles) starting with line 490. startOfFrame pulses every 420000 cycles. pixelY wraps 524→0 on the same edge pixelX wraps 799→0.
- Alignment: drive redIn = pixelX[7:0] delayed PIPE_DELAY cycles, for PIPE_DELAY=1 and 2 → the first blankN=1 cycle of each line shows vgaR=0, and the last shows vgaR=8'h7F (639 mod 256). No off-by-one at either end.
- Blank gating: constant inputs R=8'hE0, G=8'h1C, B=8'h03 → vgaR/G/B equal those values while blankN=1 and 0 while blankN=0, including lines 480..524.
- Mid-frame reset: assert resetN low at pixel (300,200) for 3 cycles → outputs at reset values within the same cycle. After release, the sequence restarts at pixelX=0, pixelY=0 with no stray hsyncN/vsyncN pulse.

Source files
------------

// File: rtl/vga_sync_out_if.sv
// Pixel-pipeline bus between the raster generator, the drawing objects and the DAC.
// master = raster generator side, slave = object mux / DAC side.
interface vga_sync_out_if;
  logic [7:0]  redIn;
  logic [7:0]  greenIn;
  logic [7:0]  blueIn;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic [7:0]  vgaR;
  logic [7:0]  vgaG;
  logic [7:0]  vgaB;
  logic        hsyncN;
  logic        vsyncN;
  logic        blankN;

  modport master (
    input  redIn, greenIn, blueIn,
    output pixelX, pixelY, startOfFrame,
    output vgaR, vgaG, vgaB, hsyncN, vsyncN, blankN
  );

  modport slave (
    output redIn, greenIn, blueIn,
    input  pixelX, pixelY, startOfFrame,
    input  vgaR, vgaG, vgaB, hsyncN, vsyncN, blankN
  );
endinterface

// File: rtl/vga_sync_out.sv
// Raster timing generator and DAC output stage: publishes the pixel coordinate,
// delays sync/blank to match the object pipeline, and registers gated color.
module vga_sync_out #(
  parameter int unsigned PIPE_DELAY = 1,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33
) (
  input  logic          clk,
  input  logic          resetN,
  vga_sync_out_if.master bus
);

  localparam int unsigned CW      = 11;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0]         r_h_count;
  logic [CW-1:0]         r_v_count;
  logic                  r_sof;
  logic                  w_h_last;
  logic                  w_v_last;
  logic                  w_active;
  logic                  w_hs;
  logic                  w_vs;
  logic [PIPE_DELAY-1:0] r_active_d;
  logic [PIPE_DELAY-1:0] r_hs_d;
  logic [PIPE_DELAY-1:0] r_vs_d;
  logic [7:0]            r_red;
  logic [7:0]            r_green;
  logic [7:0]            r_blue;
  logic                  r_hsync_n;
  logic                  r_vsync_n;
  logic                  r_blank_n;

  assign w_h_last = (r_h_count == H_LAST);
  assign w_v_last = (r_v_count == V_LAST);

  // Raw decodes of the current counter state.
  assign w_active = (r_h_count < H_VIS) && (r_v_count < V_VIS);
  assign w_hs     = (r_h_count >= HS_START) && (r_h_count < HS_END);
  assign w_vs     = (r_v_count >= VS_START) && (r_v_count < VS_END);

  // Raster counters; line and frame wrap share the same edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (w_h_last) begin
      r_h_count <= '0;
      r_v_count <= w_v_last ? '0 : r_v_count + CW'(1);
    end else begin
      r_h_count <= r_h_count + CW'(1);
    end
  end

  // Start-of-frame flag tracks the (0,0) counter state, so it is set on the wrap edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_sof <= 1'b1;
    end else begin
      r_sof <= w_h_last && w_v_last;
    end
  end

  // Delay line matching the drawing/mux latency; index 0 is the newest stage.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_active_d <= '0;
      r_hs_d     <= '0;
      r_vs_d     <= '0;
    end else begin
      r_active_d[0] <= w_active;
      r_hs_d[0]     <= w_hs;
      r_vs_d[0]     <= w_vs;
      for (int i = 1; i < int'(PIPE_DELAY); i++) begin
        r_active_d[i] <= r_active_d[i-1];
        r_hs_d[i]     <= r_hs_d[i-1];
        r_vs_d[i]     <= r_vs_d[i-1];
      end
    end
  end

  // DAC output register; color is forced to black outside the visible area.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_red     <= '0;
      r_green   <= '0;
      r_blue    <= '0;
      r_hsync_n <= 1'b1;
      r_vsync_n <= 1'b1;
      r_blank_n <= 1'b0;
    end else begin
      r_red     <= r_active_d[PIPE_DELAY-1] ? bus.redIn   : 8'h00;
      r_green   <= r_active_d[PIPE_DELAY-1] ? bus.greenIn : 8'h00;
      r_blue    <= r_active_d[PIPE_DELAY-1] ? bus.blueIn  : 8'h00;
      r_hsync_n <= ~r_hs_d[PIPE_DELAY-1];
      r_vsync_n <= ~r_vs_d[PIPE_DELAY-1];
      r_blank_n <= r_active_d[PIPE_DELAY-1];
    end
  end

  assign bus.pixelX       = r_h_count;
  assign bus.pixelY       = r_v_count;
  assign bus.startOfFrame = r_sof;
  assign bus.vgaR         = r_red;
  assign bus.vgaG         = r_green;
  assign bus.vgaB         = r_blue;
  assign bus.hsyncN       = r_hsync_n;
  assign bus.vsyncN       = r_vsync_n;
  assign bus.blankN       = r_blank_n;

endmodule

// File: tb/tb_vga_sync_out.sv
// Bench for vga_sync_out: one full-size 640x480 instance plus two shrunken rasters
// with longer pipeline delays, all checked every cycle against an arithmetic raster model.
module tb_vga_sync_out;

  logic clk;
  logic resetN;

  int checks = 0;
  int errors = 0;
  int k      = 0;   // edges since reset release
  int mode   = 0;   // 0 random, 1 pixelX-aligned red, 2 constant E0/1C/03, 3 all-ones

  logic [23:0] p0, p1, p2;   // color driven in the previous cycle, per instance
  int cnt_hs0, cnt_bl0, cnt_vs1, cnt_vs2, cnt_sof1;

  vga_sync_out_if if0 ();
  vga_sync_out_if if1 ();
  vga_sync_out_if if2 ();

  vga_sync_out #(.PIPE_DELAY(1)) u_full (
    .clk(clk), .resetN(resetN), .bus(if0)
  );

  vga_sync_out #(
    .PIPE_DELAY(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_small2 (
    .clk(clk), .resetN(resetN), .bus(if1)
  );

  vga_sync_out #(
    .PIPE_DELAY(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_small4 (
    .clk(clk), .resetN(resetN), .bus(if2)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Expected {pixelX, pixelY, startOfFrame, R, G, B, hsyncN, vsyncN, blankN} after k edges.
  function automatic logic [49:0] model(int ha, int hf, int hsw, int hb,
                                        int va, int vf, int vsw, int vb,
                                        int pd, int kk, logic [23:0] rgb);
    int ht, vt, px, py, j, hc, vc;
    logic act, h, v;
    logic [23:0] col;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    px = kk % ht;
    py = (kk / ht) % vt;
    j  = kk - pd - 1;
    if (j < 0) begin
      act = 1'b0; h = 1'b0; v = 1'b0;
    end else begin
      hc  = j % ht;
      vc  = (j / ht) % vt;
      act = (hc < ha) && (vc < va);
      h   = (hc >= ha + hf) && (hc < ha + hf + hsw);
      v   = (vc >= va + vf) && (vc < va + vf + vsw);
    end
    col = act ? rgb : 24'h0;
    return {11'(px), 11'(py), (px == 0) && (py == 0), col, ~h, ~v, act};
  endfunction

  // Color to present in cycle c; mode 1 returns the pixel presented pd cycles earlier.
  function automatic logic [23:0] stim(int md, int c, int pd, int ht);
    case (md)
      1:       return (c >= pd) ? {8'((c - pd) % ht), 16'($urandom)} : {8'h00, 16'($urandom)};
      2:       return 24'hE01C03;
      3:       return 24'hFFFFFF;
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic check_vec(string tag, logic [49:0] obs, logic [49:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp_v);
    end
  endtask

  task automatic check_int(string tag, int obs, int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    check_vec("full_pd1",
      {if0.pixelX, if0.pixelY, if0.startOfFrame, if0.vgaR, if0.vgaG, if0.vgaB,
       if0.hsyncN, if0.vsyncN, if0.blankN},
      model(640, 16, 96, 48, 480, 10, 2, 33, 1, k, p0));
    check_vec("small_pd2",
      {if1.pixelX, if1.pixelY, if1.startOfFrame, if1.vgaR, if1.vgaG, if1.vgaB,
       if1.hsyncN, if1.vsyncN, if1.blankN},
      model(16, 2, 3, 4, 6, 1, 2, 2, 2, k, p1));
    check_vec("small_pd4",
      {if2.pixelX, if2.pixelY, if2.startOfFrame, if2.vgaR, if2.vgaG, if2.vgaB,
       if2.hsyncN, if2.vsyncN, if2.blankN},
      model(16, 2, 3, 4, 6, 1, 2, 2, 4, k, p2));
  endtask

  task automatic drive_all();
    p0 = stim(mode, k, 1, 800);
    p1 = stim(mode, k, 2, 25);
    p2 = stim(mode, k, 4, 25);
    {if0.redIn, if0.greenIn, if0.blueIn} = p0;
    {if1.redIn, if1.greenIn, if1.blueIn} = p1;
    {if2.redIn, if2.greenIn, if2.blueIn} = p2;
  endtask

  task automatic clear_counts();
    cnt_hs0 = 0; cnt_bl0 = 0; cnt_vs1 = 0; cnt_vs2 = 0; cnt_sof1 = 0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (resetN) k++;
      @(negedge clk);
      check_all();
      if (!if0.hsyncN)      cnt_hs0++;
      if (if0.blankN)       cnt_bl0++;
      if (!if1.vsyncN)      cnt_vs1++;
      if (!if2.vsyncN)      cnt_vs2++;
      if (if1.startOfFrame) cnt_sof1++;
      drive_all();
    end
  endtask

  initial begin
    resetN = 1'b0;
    k      = 0;
    mode   = 3;
    p0 = '0; p1 = '0; p2 = '0;
    clear_counts();
    drive_all();
    run(3);

    // Release; first edge must bring pixelX to 1.
    resetN = 1'b1;
    mode   = 0;
    run(800);

    clear_counts();
    run(800);
    check_int("full_hsync_low_per_line", cnt_hs0, 96);
    check_int("full_blank_high_per_line", cnt_bl0, 640);
    run(300);
    check_int("small_pd2_vsync_low_4_frames", cnt_vs1, 200);
    check_int("small_pd4_vsync_low_4_frames", cnt_vs2, 200);
    check_int("small_sof_pulses_4_frames", cnt_sof1, 4);

    mode = 1;
    run(2000);
    mode = 2;
    run(1000);
    mode = 0;
    run(437);

    // Asynchronous mid-line reset: outputs must fall back immediately.
    #2;
    resetN = 1'b0;
    k      = 0;
    #1;
    check_all();
    run(3);
    resetN = 1'b1;
    run(1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
